calc_seq_ctrl: RTL and testbench

//  Parametrised signed calculator sequencer; next generation of the two-operand controller.

---
 rtl/calc_pkg.sv | 33 +++
 rtl/calc_digit_acc.sv | 56 +++++
 rtl/calc_seq_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator sequencer: operator codes, FSM states,
// operator validation and the signed add/sub overflow rule.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_MUL  = 3'b100
  } op_t;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESULT  = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  function automatic logic op_is_valid(input logic [2:0] code);
    return (code == OP_ADD) || (code == OP_SUB) || (code == OP_MUL);
  endfunction

  // Subtraction adds -B, so B's sign is inverted; B==0 is harmless because a-0 never flips sign.
  function automatic logic add_overflow(input logic a_sign, input logic b_sign,
                                        input logic r_sign, input logic sub);
    logic b_eff;
    b_eff = sub ? ~b_sign : b_sign;
    return (a_sign == b_eff) && (r_sign != a_sign);
  endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// Decimal operand accumulator: builds a magnitude digit by digit with a sign flag,
// and can be loaded with a signed value (used when a result is chained into A).
module calc_digit_acc #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             neg_toggle,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] value
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic [WIDTH-1:0] mag;
  logic [CW-1:0]    count;
  logic             neg;
  logic [WIDTH-1:0] digit_ext;

  assign digit_ext = WIDTH'(digit);

  // clear together with digit_valid starts a fresh operand holding that single digit.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      mag   <= '0;
      count <= '0;
      neg   <= 1'b0;
    end else if (load) begin
      mag   <= load_value[WIDTH-1] ? -load_value : load_value;
      neg   <= load_value[WIDTH-1];
      count <= CW'(MAX_DIGITS);
    end else if (clear) begin
      neg <= 1'b0;
      if (digit_valid) begin
        mag   <= digit_ext;
        count <= CW'(1);
      end else begin
        mag   <= '0;
        count <= '0;
      end
    end else if (neg_toggle) begin
      neg <= ~neg;
    end else if (digit_valid && (count < CW'(MAX_DIGITS))) begin
      mag   <= mag * WIDTH'(10) + digit_ext;
      count <= count + CW'(1);
    end
  end

  assign value = neg ? -mag : mag;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Signed calculator sequencer: collects two operands and an operator, issues the operation
// to the add/sub or multiply unit, and handles chaining, clear, overflow and timeout.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             key_valid,
  input  logic [3:0]       key_digit,
  input  logic             neg_toggle,
  input  logic             op_valid,
  input  logic [2:0]       op_sel,
  input  logic             equal_input,
  input  logic             clear_input,
  output logic             alu_start,
  output logic             alu_sub,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic             alu_finish,
  input  logic [WIDTH-1:0] alu_out,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_in1,
  output logic [WIDTH-1:0] mul_in2,
  input  logic             mul_finish,
  input  logic [WIDTH-1:0] mul_out,
  output logic             complete,
  output logic             error,
  output logic [WIDTH-1:0] display_output,
  output state_t           dbg_state
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state, state_n;
  op_t              op, op_n;
  logic [WIDTH-1:0] result, result_n;
  logic [TW-1:0]    timer, timer_n;

  logic [WIDTH-1:0] a_value, b_value;
  logic a_clear, a_load, a_neg, a_dig;
  logic b_clear, b_neg, b_dig;

  // Handshake: alu_start/mul_start are single-cycle pulses in ISSUE; operands and alu_sub stay
  // stable until the selected unit's finish strobe is accepted in WAIT; finishes elsewhere are dropped.

  // One-hot event decode implementing clear > equal > op > neg > digit.
  logic op_ok, dig_ok;
  logic eq_ev, op_ev, neg_ev, dig_ev;
  assign op_ok  = op_valid && op_is_valid(op_sel);
  assign dig_ok = key_valid && (key_digit <= 4'd9);
  assign eq_ev  = !clear_input && equal_input;
  assign op_ev  = !clear_input && !equal_input && op_ok;
  assign neg_ev = !clear_input && !equal_input && !op_ok && neg_toggle;
  assign dig_ev = !clear_input && !equal_input && !op_ok && !neg_toggle && dig_ok;

  logic is_mul, sel_finish;
  assign is_mul     = (op == OP_MUL);
  assign sel_finish = is_mul ? mul_finish : alu_finish;

  always_comb begin
    state_n  = state;
    op_n     = op;
    result_n = result;
    timer_n  = timer;
    a_clear  = 1'b0;
    a_load   = 1'b0;
    a_neg    = 1'b0;
    a_dig    = 1'b0;
    b_clear  = 1'b0;
    b_neg    = 1'b0;
    b_dig    = 1'b0;
    case (state)
      ST_ENTER_A: begin
        if (op_ev) begin
          op_n    = op_t'(op_sel);
          state_n = ST_ENTER_B;
        end else if (neg_ev) begin
          a_neg = 1'b1;
        end else if (dig_ev) begin
          a_dig = 1'b1;
        end
      end
      ST_ENTER_B: begin
        if (eq_ev) begin
          state_n = ST_ISSUE;
        end else if (op_ev) begin
          op_n = op_t'(op_sel);
        end else if (neg_ev) begin
          b_neg = 1'b1;
        end else if (dig_ev) begin
          b_dig = 1'b1;
        end
      end
      ST_ISSUE: begin
        timer_n = '0;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (sel_finish) begin
          result_n = is_mul ? mul_out : alu_out;
          if (!is_mul && add_overflow(a_value[WIDTH-1], b_value[WIDTH-1],
                                      alu_out[WIDTH-1], op == OP_SUB))
            state_n = ST_ERROR;
          else
            state_n = ST_RESULT;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          state_n = ST_ERROR;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      ST_RESULT: begin
        if (eq_ev) begin
          a_load  = 1'b1;
          state_n = ST_ISSUE;
        end else if (op_ev) begin
          a_load  = 1'b1;
          b_clear = 1'b1;
          op_n    = op_t'(op_sel);
          state_n = ST_ENTER_B;
        end else if (dig_ev) begin
          a_clear = 1'b1;
          a_dig   = 1'b1;
          b_clear = 1'b1;
          state_n = ST_ENTER_A;
        end
      end
      ST_ERROR: ;
      default: state_n = ST_ENTER_A;
    endcase
    if (clear_input) begin
      state_n  = ST_ENTER_A;
      op_n     = OP_NONE;
      result_n = '0;
      timer_n  = '0;
      a_clear  = 1'b1;
      b_clear  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state  <= ST_ENTER_A;
      op     <= OP_NONE;
      result <= '0;
      timer  <= '0;
    end else begin
      state  <= state_n;
      op     <= op_n;
      result <= result_n;
      timer  <= timer_n;
    end
  end

  calc_digit_acc #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
    .clk        (clk),
    .nRST       (nRST),
    .clear      (a_clear),
    .load       (a_load),
    .load_value (result),
    .neg_toggle (a_neg),
    .digit_valid(a_dig),
    .digit      (key_digit),
    .value      (a_value)
  );

  calc_digit_acc #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
    .clk        (clk),
    .nRST       (nRST),
    .clear      (b_clear),
    .load       (1'b0),
    .load_value ('0),
    .neg_toggle (b_neg),
    .digit_valid(b_dig),
    .digit      (key_digit),
    .value      (b_value)
  );

  logic busy;
  assign busy = (state == ST_ISSUE) || (state == ST_WAIT);

  assign alu_start = (state == ST_ISSUE) && !is_mul && !clear_input;
  assign mul_start = (state == ST_ISSUE) && is_mul && !clear_input;
  assign alu_sub   = busy && (op == OP_SUB);
  assign alu_in1   = (busy && !is_mul) ? a_value : '0;
  assign alu_in2   = (busy && !is_mul) ? b_value : '0;
  assign mul_in1   = (busy && is_mul) ? a_value : '0;
  assign mul_in2   = (busy && is_mul) ? b_value : '0;
  assign complete  = (state == ST_RESULT);
  assign error     = (state == ST_ERROR);
  assign dbg_state = state;

  always_comb begin
    display_output = '0;
    case (state)
      ST_ENTER_A:                    display_output = a_value;
      ST_ENTER_B:                    display_output = b_value;
      ST_ISSUE, ST_WAIT, ST_RESULT:  display_output = result;
      default:                       display_output = '0;
    endcase
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl: directed scenarios plus randomized chained
// calculations checked against an integer-arithmetic reference model.
module tb_calc_seq_ctrl;
  import calc_pkg::*;

  localparam int W  = 16;
  localparam int MD = 4;
  localparam int TO = 64;

  logic         clk, nRST;
  logic         key_valid, neg_toggle, op_valid, equal_input, clear_input;
  logic [3:0]   key_digit;
  logic [2:0]   op_sel;
  logic         alu_start, alu_sub, alu_finish, mul_start, mul_finish;
  logic [W-1:0] alu_in1, alu_in2, alu_out, mul_in1, mul_in2, mul_out;
  logic         complete, error;
  logic [W-1:0] display_output;
  state_t       dbg_state;

  calc_seq_ctrl #(.WIDTH(W), .MAX_DIGITS(MD), .TIMEOUT(TO)) dut (
    .clk(clk), .nRST(nRST), .key_valid(key_valid), .key_digit(key_digit),
    .neg_toggle(neg_toggle), .op_valid(op_valid), .op_sel(op_sel),
    .equal_input(equal_input), .clear_input(clear_input),
    .alu_start(alu_start), .alu_sub(alu_sub), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_finish(alu_finish), .alu_out(alu_out),
    .mul_start(mul_start), .mul_in1(mul_in1), .mul_in2(mul_in2),
    .mul_finish(mul_finish), .mul_out(mul_out),
    .complete(complete), .error(error), .display_output(display_output),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int alu_starts = 0;
  int mul_starts = 0;
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (alu_start) alu_starts++;
    if (mul_start) mul_starts++;
  end

  // driver tasks
  task automatic press_digit(input int d);
    @(negedge clk); key_valid = 1'b1; key_digit = 4'(d);
    @(negedge clk); key_valid = 1'b0;
  endtask

  task automatic press_op(input logic [2:0] code);
    @(negedge clk); op_valid = 1'b1; op_sel = code;
    @(negedge clk); op_valid = 1'b0;
  endtask

  task automatic press_neg();
    @(negedge clk); neg_toggle = 1'b1;
    @(negedge clk); neg_toggle = 1'b0;
  endtask

  task automatic press_equal();
    @(negedge clk); equal_input = 1'b1;
    @(negedge clk); equal_input = 1'b0;
  endtask

  task automatic press_clear();
    @(negedge clk); clear_input = 1'b1;
    @(negedge clk); clear_input = 1'b0;
  endtask

  task automatic enter_number(input int mag, input bit neg);
    int digs[$];
    int m;
    m = mag;
    if (m == 0) digs.push_front(0);
    while (m > 0) begin
      digs.push_front(m % 10);
      m = m / 10;
    end
    foreach (digs[i]) press_digit(digs[i]);
    if (neg) press_neg();
  endtask

  // Acts as the selected arithmetic unit: expects the start pulse right after equal,
  // checks the operands, then returns unit_out after lat cycles.
  task automatic run_unit(input bit is_mul, input logic [W-1:0] e1, input logic [W-1:0] e2,
                          input bit e_sub, input logic [W-1:0] unit_out, input int lat);
    bit found;
    int seen;
    found = 1'b0;
    seen  = -1;
    for (int i = 0; i < 8; i++) begin
      if (alu_start || mul_start) begin
        found = 1'b1;
        seen  = i;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found || seen != 0) begin
      errors++;
      $display("FAIL start_latency: seen after %0d cycles, expected 0", seen);
    end
    if (!found) return;
    checks++;
    if (is_mul) begin
      if (mul_start !== 1'b1 || alu_start !== 1'b0 || mul_in1 !== e1 || mul_in2 !== e2) begin
        errors++;
        $display("FAIL mul_issue: start=%b/%b in1=%0h in2=%0h expected 1/0 %0h %0h",
                 mul_start, alu_start, mul_in1, mul_in2, e1, e2);
      end
    end else begin
      if (alu_start !== 1'b1 || mul_start !== 1'b0 || alu_in1 !== e1 || alu_in2 !== e2 ||
          alu_sub !== e_sub) begin
        errors++;
        $display("FAIL alu_issue: start=%b/%b in1=%0h in2=%0h sub=%b expected 1/0 %0h %0h %b",
                 alu_start, mul_start, alu_in1, alu_in2, alu_sub, e1, e2, e_sub);
      end
    end
    @(negedge clk);
    checks++;
    if ((is_mul ? mul_in1 : alu_in1) !== e1 || alu_start !== 1'b0 || mul_start !== 1'b0) begin
      errors++;
      $display("FAIL wait_hold: in1=%0h start=%b/%b expected %0h 0/0",
               is_mul ? mul_in1 : alu_in1, alu_start, mul_start, e1);
    end
    repeat (lat - 1) @(negedge clk);
    if (is_mul) begin mul_finish = 1'b1; mul_out = unit_out; end
    else        begin alu_finish = 1'b1; alu_out = unit_out; end
    @(negedge clk);
    mul_finish = 1'b0;
    alu_finish = 1'b0;
  endtask

  // scenario tasks
  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({alu_start, mul_start, complete, error, alu_sub} !== 5'b0 || display_output !== '0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b display=%0h expected 0", 
               {alu_start, mul_start, complete, error, alu_sub}, display_output);
    end
    nRST = 1'b1;
    @(negedge clk);
    checks++;
    if ({alu_in1, alu_in2, mul_in1, mul_in2} !== '0 || dbg_state !== ST_ENTER_A) begin
      errors++;
      $display("FAIL reset_state: operands=%0h state=%0d expected 0 ENTER_A",
               {alu_in1, alu_in2, mul_in1, mul_in2}, dbg_state);
    end
  endtask

  task automatic test_add_basic();
    int s_alu, s_mul;
    press_clear();
    enter_number(12, 0);
    checks++;
    if (display_output !== 16'd12) begin
      errors++; $display("FAIL add_entry_a: display=%0d expected 12", display_output);
    end
    press_op(OP_ADD);
    enter_number(34, 0);
    checks++;
    if (display_output !== 16'd34) begin
      errors++; $display("FAIL add_entry_b: display=%0d expected 34", display_output);
    end
    s_alu = alu_starts; s_mul = mul_starts;
    press_equal();
    run_unit(1'b0, 16'd12, 16'd34, 1'b0, 16'd46, 3);
    checks++;
    if (complete !== 1'b1 || error !== 1'b0 || display_output !== 16'd46) begin
      errors++;
      $display("FAIL add_result: complete=%b error=%b display=%0d expected 1 0 46",
               complete, error, display_output);
    end
    checks++;
    if (alu_starts != s_alu + 1 || mul_starts != s_mul) begin
      errors++;
      $display("FAIL add_pulses: alu=%0d mul=%0d expected %0d %0d",
               alu_starts - s_alu, mul_starts - s_mul, 1, 0);
    end
  endtask

  task automatic test_chain_mul();
    int s_alu;
    s_alu = alu_starts;
    press_op(OP_MUL);
    checks++;
    if (display_output !== 16'd0) begin
      errors++; $display("FAIL chain_b_cleared: display=%0d expected 0", display_output);
    end
    enter_number(2, 0);
    press_equal();
    run_unit(1'b1, 16'd46, 16'd2, 1'b0, 16'd92, 2);
    checks++;
    if (complete !== 1'b1 || display_output !== 16'd92 || alu_starts != s_alu) begin
      errors++;
      $display("FAIL chain_result: complete=%b display=%0d alu_pulses=%0d expected 1 92 0",
               complete, display_output, alu_starts - s_alu);
    end
  endtask

  task automatic test_neg_sub();
    press_clear();
    enter_number(9999, 1);
    checks++;
    if (display_output !== 16'(-9999)) begin
      errors++; $display("FAIL neg_entry: display=%0h expected %0h", display_output, 16'(-9999));
    end
    press_op(OP_SUB);
    enter_number(9999, 0);
    press_equal();
    run_unit(1'b0, 16'(-9999), 16'd9999, 1'b1, 16'(-19998), 2);
    checks++;
    if (complete !== 1'b1 || error !== 1'b0 || display_output !== 16'hB1E2) begin
      errors++;
      $display("FAIL neg_sub_result: complete=%b error=%b display=%0h expected 1 0 b1e2",
               complete, error, display_output);
    end
  endtask

  task automatic test_overflow();
    press_clear();
    enter_number(9999, 0);
    press_op(OP_MUL);
    enter_number(3, 0);
    press_equal();
    run_unit(1'b1, 16'd9999, 16'd3, 1'b0, 16'd29997, 1);
    press_op(OP_ADD);
    enter_number(9999, 0);
    press_equal();
    run_unit(1'b0, 16'd29997, 16'd9999, 1'b0, 16'(39996), 1);
    checks++;
    if (error !== 1'b1 || complete !== 1'b0 || display_output !== 16'd0) begin
      errors++;
      $display("FAIL overflow_error: error=%b complete=%b display=%0h expected 1 0 0",
               error, complete, display_output);
    end
    press_equal();
    press_digit(5);
    checks++;
    if (error !== 1'b1) begin
      errors++; $display("FAIL overflow_sticky: error=%b expected 1", error);
    end
    press_clear();
    checks++;
    if (error !== 1'b0 || dbg_state !== ST_ENTER_A || display_output !== 16'd0) begin
      errors++;
      $display("FAIL overflow_clear: error=%b state=%0d display=%0h expected 0 ENTER_A 0",
               error, dbg_state, display_output);
    end
  endtask

  task automatic test_timeout();
    int first_err;
    press_clear();
    enter_number(5, 0);
    press_op(OP_MUL);
    enter_number(6, 0);
    press_equal();
    checks++;
    if (mul_start !== 1'b1) begin
      errors++; $display("FAIL timeout_start: mul_start=%b expected 1", mul_start);
    end
    @(negedge clk);
    first_err = -1;
    for (int k = 1; k <= TO + 4; k++) begin
      @(negedge clk);
      alu_finish = 1'b0;
      if (k == 5) begin alu_finish = 1'b1; alu_out = 16'd7; end
      if (complete === 1'b1) first_err = -2;
      if (error === 1'b1 && first_err == -1) first_err = k;
    end
    alu_finish = 1'b0;
    checks++;
    if (first_err != TO) begin
      errors++;
      $display("FAIL timeout_cycles: error after %0d cycles in WAIT, expected %0d", first_err, TO);
    end
    press_clear();
  endtask

  task automatic test_priority_limits();
    int s_alu, s_mul;
    press_clear();
    for (int d = 1; d <= 5; d++) press_digit(d);
    checks++;
    if (display_output !== 16'd1234) begin
      errors++; $display("FAIL digit_limit: display=%0d expected 1234", display_output);
    end
    press_clear();
    press_digit(4);
    @(negedge clk); neg_toggle = 1'b1; key_valid = 1'b1; key_digit = 4'd5;
    @(negedge clk); neg_toggle = 1'b0; key_valid = 1'b0;
    checks++;
    if (display_output !== 16'(-4)) begin
      errors++; $display("FAIL neg_over_digit: display=%0h expected %0h", display_output, 16'(-4));
    end
    @(negedge clk); op_valid = 1'b1; op_sel = OP_ADD; key_valid = 1'b1; key_digit = 4'd8;
    @(negedge clk); op_valid = 1'b0; key_valid = 1'b0;
    checks++;
    if (dbg_state !== ST_ENTER_B || display_output !== 16'd0) begin
      errors++;
      $display("FAIL op_over_digit: state=%0d display=%0d expected ENTER_B 0", dbg_state, display_output);
    end
    press_digit(7);
    s_alu = alu_starts; s_mul = mul_starts;
    @(negedge clk); clear_input = 1'b1; equal_input = 1'b1;
    @(negedge clk); clear_input = 1'b0; equal_input = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dbg_state !== ST_ENTER_A || display_output !== 16'd0 ||
        alu_starts != s_alu || mul_starts != s_mul) begin
      errors++;
      $display("FAIL clear_over_equal: state=%0d display=%0d pulses=%0d expected ENTER_A 0 0",
               dbg_state, display_output, (alu_starts - s_alu) + (mul_starts - s_mul));
    end
  endtask

  task automatic test_repeat_equal();
    press_clear();
    enter_number(5, 0);
    press_op(OP_ADD);
    enter_number(3, 0);
    press_equal();
    run_unit(1'b0, 16'd5, 16'd3, 1'b0, 16'd8, 1);
    press_equal();
    run_unit(1'b0, 16'd8, 16'd3, 1'b0, 16'd11, 2);
    checks++;
    if (complete !== 1'b1 || display_output !== 16'd11) begin
      errors++;
      $display("FAIL repeat_equal: complete=%b display=%0d expected 1 11", complete, display_output);
    end
    press_digit(7);
    checks++;
    if (complete !== 1'b0 || dbg_state !== ST_ENTER_A || display_output !== 16'd7) begin
      errors++;
      $display("FAIL fresh_a: complete=%b state=%0d display=%0d expected 0 ENTER_A 7",
               complete, dbg_state, display_output);
    end
  endtask

  task automatic test_random();
    bit have_res;
    logic [W-1:0] prev;
    have_res = 1'b0;
    prev = '0;
    for (int it = 0; it < 30; it++) begin
      int a, b, a_mag, b_mag, ndig, res_true, sel;
      bit a_neg, b_neg, ovf, is_mul;
      logic [2:0] code;
      logic [W-1:0] unit_out;
      sel  = $urandom_range(0, 2);
      code = (sel == 0) ? OP_ADD : (sel == 1) ? OP_SUB : OP_MUL;
      is_mul = (sel == 2);
      if (have_res && $urandom_range(0, 1) == 1) begin
        a = int'($signed(prev));
      end else begin
        press_clear();
        ndig  = $urandom_range(1, MD);
        a_mag = 0;
        for (int i = 0; i < ndig; i++) a_mag = a_mag * 10 + $urandom_range(0, 9);
        a_neg = $urandom_range(0, 1);
        enter_number(a_mag, a_neg);
        a = a_neg ? -a_mag : a_mag;
        checks++;
        if (display_output !== 16'(a)) begin
          errors++; $display("FAIL rand_a[%0d]: display=%0h expected %0h", it, display_output, 16'(a));
        end
      end
      press_op(code);
      ndig  = $urandom_range(1, MD);
      b_mag = 0;
      for (int i = 0; i < ndig; i++) b_mag = b_mag * 10 + $urandom_range(0, 9);
      b_neg = $urandom_range(0, 1);
      enter_number(b_mag, b_neg);
      b = b_neg ? -b_mag : b_mag;
      res_true = (sel == 0) ? a + b : (sel == 1) ? a - b : a * b;
      unit_out = res_true[W-1:0];
      ovf = !is_mul && (res_true > 32767 || res_true < -32768);
      if (!ovf) exp_q.push_back(unit_out);
      press_equal();
      run_unit(is_mul, 16'(a), 16'(b), sel == 1, unit_out, $urandom_range(1, 6));
      checks++;
      if (ovf) begin
        if (error !== 1'b1 || display_output !== 16'd0) begin
          errors++;
          $display("FAIL rand_ovf[%0d]: error=%b display=%0h expected 1 0", it, error, display_output);
        end
        have_res = 1'b0;
      end else begin
        prev = exp_q.pop_front();
        if (complete !== 1'b1 || display_output !== prev) begin
          errors++;
          $display("FAIL rand_res[%0d]: complete=%b display=%0h expected 1 %0h",
                   it, complete, display_output, prev);
        end
        have_res = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    press_clear();
    enter_number(3, 0);
    press_op(OP_ADD);
    enter_number(4, 0);
    press_equal();
    @(negedge clk);
    nRST = 1'b0;
    #1;
    checks++;
    if ({alu_start, mul_start, complete, error, alu_sub} !== 5'b0 ||
        {alu_in1, alu_in2, display_output} !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: flags=%b in=%0h/%0h display=%0h expected all 0",
               {alu_start, mul_start, complete, error, alu_sub}, alu_in1, alu_in2, display_output);
    end
    @(negedge clk);
    nRST = 1'b1;
    alu_finish = 1'b1; alu_out = 16'd7;
    @(negedge clk);
    alu_finish = 1'b0;
    checks++;
    if (complete !== 1'b0 || display_output !== 16'd0) begin
      errors++;
      $display("FAIL late_finish: complete=%b display=%0d expected 0 0", complete, display_output);
    end
  endtask

  initial begin
    nRST = 1'b0; key_valid = 1'b0; key_digit = 4'd0; neg_toggle = 1'b0;
    op_valid = 1'b0; op_sel = 3'b000; equal_input = 1'b0; clear_input = 1'b0;
    alu_finish = 1'b0; alu_out = '0; mul_finish = 1'b0; mul_out = '0;
    test_reset();
    test_add_basic();
    test_chain_mul();
    test_neg_sub();
    test_overflow();
    test_timeout();
    test_priority_limits();
    test_repeat_equal();
    test_random();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
